// File: rtl/led_bank_arbiter_if.sv
// LED-bank arbiter pin bundle: raw buttons in, LED bank and grant status out.
// The arbiter connects through the slave modport and the board/bench through the master modport.
interface led_bank_arbiter_if;
  logic [2:0] BTN;
  logic [4:0] LED;
  logic       LEDR_N;
  logic       LEDG_N;
  logic [2:0] grant;
  logic       busy;

  modport master (
    output BTN,
    input  LED,
    input  LEDR_N,
    input  LEDG_N,
    input  grant,
    input  busy
  );

  modport slave (
    input  BTN,
    output LED,
    output LEDR_N,
    output LEDG_N,
    output grant,
    output busy
  );
endinterface

// File: rtl/led_bank_arbiter.sv
// Shares the LED bank between three debounced buttons using a round-robin
// arbiter. Each grant lasts a fixed number of cycles.
module led_bank_arbiter #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int HOLD_CYCLES     = 6000000
) (
  input  logic               CLK,
  input  logic               RST_N,
  led_bank_arbiter_if.slave  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_db_level;
  logic [2:0]        r_db_prev;
  logic [DB_W-1:0]   r_db_cnt [3];
  logic [2:0]        r_pending;
  logic [1:0]        r_last;
  logic [HOLD_W-1:0] r_hold;
  state_t            r_state;
  logic [2:0]        r_grant;
  logic              r_busy;
  logic              r_pend_led;
  logic              r_ledr_n;
  logic              r_ledg_n;

  logic [2:0]        w_rise;
  logic              w_pick_valid;
  logic [1:0]        w_pick_idx;
  logic [2:0]        w_clr;
  logic [2:0]        w_pend_nxt;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.BTN;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_db_level <= '0;
      r_db_prev  <= '0;
      // NOTE: the counter array is tiny and must start from zero after reset,
      // so it is reset like ordinary flops rather than left as uninitialised storage.
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_db_prev <= r_db_level;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db_level[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_level[i] <= r_sync2[i];
            r_db_cnt[i]   <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_rise = r_db_level & ~r_db_prev;

  // Search last+1, last+2, last+3 (mod 3). Walking backwards lets the
  // nearest candidate overwrite the farther ones.
  always_comb begin
    // NOTE: defaults first, so no path through this block can infer a latch.
    w_pick_valid = 1'b0;
    w_pick_idx   = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      logic [1:0] j;
      j = 2'((int'(r_last) + k) % 3);
      if (r_pending[j]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = j;
      end
    end
  end

  assign w_clr      = (r_state == S_IDLE && w_pick_valid) ? 3'(3'b001 << w_pick_idx) : 3'b000;
  // A new rising edge in the same cycle as a grant clear keeps the request queued.
  assign w_pend_nxt = (r_pending & ~w_clr) | w_rise;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_last     <= 2'd2;
      r_hold     <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_pend_led <= 1'b0;
      r_ledr_n   <= 1'b1;
      r_ledg_n   <= 1'b0;
    end else begin
      r_pending  <= w_pend_nxt;
      r_pend_led <= |w_pend_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_state  <= S_GRANT;
            r_grant  <= w_clr;
            r_last   <= w_pick_idx;
            r_hold   <= HOLD_LOAD;
            r_busy   <= 1'b1;
            r_ledr_n <= 1'b0;
            r_ledg_n <= 1'b1;
          end
        end
        S_GRANT: begin
          if (r_hold == '0) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_ledr_n <= 1'b1;
            r_ledg_n <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.LED    = {r_busy, r_pend_led, r_grant};
  assign bus.grant  = r_grant;
  assign bus.busy   = r_busy;
  assign bus.LEDR_N = r_ledr_n;
  assign bus.LEDG_N = r_ledg_n;

  a_grant_onehot : assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(r_grant));
  a_busy_grant   : assert property (@(posedge CLK) disable iff (!RST_N) r_busy == (|r_grant));
  a_leds_follow  : assert property (@(posedge CLK) disable iff (!RST_N) r_ledr_n == ~r_busy && r_ledg_n == r_busy);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
// Expected values below are hand-derived from the button-to-grant timing.
module tb_led_bank_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  led_bank_arbiter_if u_if();

  led_bank_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8)
  ) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (u_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant, checks its owner and its length.
  // idle returns the number of cycles spent waiting; led0 is LED at grant start.
  task automatic grant_run(input string tag, input logic [2:0] exp,
                           output int idle, output logic [4:0] led0);
    int len;
    idle = 0;
    while (u_if.grant == 3'b000 && idle < 40) begin
      step(1);
      idle++;
    end
    led0 = u_if.LED;
    check({tag, "_owner"}, 32'(u_if.grant), 32'(exp));
    len = 0;
    while (u_if.grant == exp && len < 20) begin
      len++;
      step(1);
    end
    check({tag, "_len"}, len, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         idle;
    int         starts;
    int         waited;
    logic       seen;
    logic [2:0] prev_grant;
    logic [4:0] led0;

    // Reset values
    u_if.BTN = 3'b000;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("rst_led",    32'(u_if.LED),    32'h00);
    check("rst_grant",  32'(u_if.grant),  32'h0);
    check("rst_busy",   32'(u_if.busy),   32'h0);
    check("rst_ledr_n", 32'(u_if.LEDR_N), 32'h1);
    check("rst_ledg_n", 32'(u_if.LEDG_N), 32'h0);

    // 3-cycle pulse on BTN1 must be filtered out
    u_if.BTN = 3'b010;
    step(3);
    u_if.BTN = 3'b000;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (u_if.grant != 3'b000 || u_if.LED[3]) seen = 1'b1;
    end
    check("glitch_no_activity", 32'(seen), 32'h0);

    // BTN1 held: grant arrives 8 cycles after the pin changes
    u_if.BTN = 3'b010;
    step(7);
    check("lat_before", 32'(u_if.grant), 32'h0);
    step(1);
    check("lat_grant",  32'(u_if.grant),  32'h2);
    check("lat_led",    32'(u_if.LED),    32'b10010);
    check("lat_ledr_n", 32'(u_if.LEDR_N), 32'h0);
    check("lat_ledg_n", 32'(u_if.LEDG_N), 32'h1);
    check("lat_busy",   32'(u_if.busy),   32'h1);
    grant_run("held1", 3'b010, idle, led0);
    u_if.BTN = 3'b000;
    step(10);

    // Pointer fairness: last=1, so the search starts at 2 and finds 0 first
    u_if.BTN = 3'b011;
    grant_run("fair_a", 3'b001, idle, led0);
    grant_run("fair_b", 3'b010, idle, led0);
    check("fair_gap", idle, 1);
    u_if.BTN = 3'b000;
    step(10);

    // Round-robin from reset with all three requesting
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    u_if.BTN = 3'b111;
    grant_run("rr0", 3'b001, idle, led0);
    check("rr0_pend_led", 32'(led0[3]), 32'h1);
    grant_run("rr1", 3'b010, idle, led0);
    check("rr1_gap", idle, 1);
    check("rr1_pend_led", 32'(led0[3]), 32'h1);
    grant_run("rr2", 3'b100, idle, led0);
    check("rr2_gap", idle, 1);
    check("rr2_pend_led", 32'(led0[3]), 32'h0);
    u_if.BTN = 3'b000;
    step(10);

    // Owner re-presses during its own grant: queued, never extended
    u_if.BTN = 3'b100;
    step(4);
    u_if.BTN = 3'b000;
    step(4);
    check("rereq_start", 32'(u_if.grant), 32'h4);
    u_if.BTN = 3'b100;
    grant_run("rereq0", 3'b100, idle, led0);
    grant_run("rereq1", 3'b100, idle, led0);
    check("rereq_gap", idle, 1);
    u_if.BTN = 3'b000;
    step(10);

    // Long hold with a 2-cycle low glitch gives exactly one grant
    starts = 0;
    prev_grant = u_if.grant;
    for (int c = 0; c < 80; c++) begin
      u_if.BTN = (c < 50 && c != 20 && c != 21) ? 3'b001 : 3'b000;
      step(1);
      if (prev_grant == 3'b000 && u_if.grant != 3'b000) starts++;
      prev_grant = u_if.grant;
    end
    check("hold_starts",   starts, 1);
    check("hold_end_grant", 32'(u_if.grant),  32'h0);
    check("hold_end_pend",  32'(u_if.LED[3]), 32'h0);

    // Asynchronous reset in the middle of a grant
    u_if.BTN = 3'b010;
    waited = 0;
    while (u_if.grant == 3'b000 && waited < 30) begin
      step(1);
      waited++;
    end
    check("areset_pre_grant", 32'(u_if.grant), 32'h2);
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_led",    32'(u_if.LED),    32'h00);
    check("areset_grant",  32'(u_if.grant),  32'h0);
    check("areset_busy",   32'(u_if.busy),   32'h0);
    check("areset_ledr_n", 32'(u_if.LEDR_N), 32'h1);
    check("areset_ledg_n", 32'(u_if.LEDG_N), 32'h0);
    u_if.BTN = 3'b000;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_reset_led", 32'(u_if.LED), 32'h00);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the board LED bank (LED1..LED5 plus the red/green status pair) between the three user buttons BTN1..BTN3, treated as requesters.
- Each button press is synchronised, debounced and queued as a sticky request. A round-robin arbiter grants the bank to one requester for a fixed hold time.
- Sits between the raw button pins and the LED pins in top, replacing the direct button-to-LED wiring.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable synchronised samples required to accept a new button level (10 ms at 12 MHz); minimum 2.
- HOLD_CYCLES, 6000000, grant duration in CLK cycles (0.5 s at 12 MHz); minimum 2.

Ports:
- CLK  input  1  system clock, 12 MHz.
- RST_N  input  1  asynchronous active-low reset.
- BTN  input  3  raw buttons, active-high, asynchronous to CLK; BTN[0]=BTN1 … BTN[2]=BTN3.
- LED  output  5  LED1..LED5 drive, active-high.
- LEDR_N  output  1  red LED, active-low.
- LEDG_N  output  1  green LED, active-low.
- grant  output  3  one-hot current owner; 000 when idle.
- busy  output  1  high while a grant is active.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (RST_N). Assertion at any time, including mid-grant or mid-debounce, immediately clears:
  - synchronisers, debounced levels, debounce counters, pending bits, hold counter;
  - the round-robin pointer, to last=2, so requester 0 has first priority;
  - outputs: LED=00000, grant=000, busy=0, LEDR_N=1, LEDG_N=0.
- Synchroniser: 2-flop per BTN bit, reset value 0.
- Debounce, per bit:
  - A counter increments while the synchronised sample differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the sample and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the level.
- Request capture: a debounced rising edge (level 0→1) sets pending[i] on the next clock. Falling edges are ignored. Holding a button gives exactly one request.
- FSM states IDLE and GRANT, all outputs registered:
  - IDLE, pending==000: stay in IDLE.
  - IDLE, pending!=000: select the first set pending bit searching last+1, last+2, last+3 (mod 3). Set grant to that one-hot index, set last=index, clear pending[index], load hold counter with HOLD_CYCLES-1, go to GRANT.
  - GRANT: decrement the hold counter each cycle. When it is 0, clear grant and go to IDLE. Grant is therefore high for exactly HOLD_CYCLES cycles.
  - After GRANT, at least one IDLE cycle always occurs before the next grant.
- Simultaneous set/clear of the same pending bit in one cycle: set wins, so the request stays queued.
- A press by the current owner during GRANT queues a new request. It never extends the current grant.
- Latency: with the FSM in IDLE and no other pending bits, grant is asserted 2 cycles after the debounced level rises (pending set at +1, grant at +2).
- LED map, registered with the FSM:
  - LED[i] = grant[i] for i=0..2.
  - LED[3] = (pending != 000).
  - LED[4] = busy.
  - busy = (state==GRANT).
  - LEDR_N = ~busy; LEDG_N = busy (red while owned, green while free).
- No counter wraps. The hold counter stops at 0 and the debounce counter clears on acceptance.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
- Reset values: hold RST_N=0 for 3 cycles, then release → LED=00000, grant=000, busy=0, LEDR_N=1, LEDG_N=0. Assert RST_N=0 asynchronously mid-grant → all outputs return to these values without waiting for a CLK edge.
- Debounce: BTN[1] high for 3 cycles then low → no grant, pending stays 000. BTN[1] held high 10 cycles → grant=010 for exactly 8 cycles, LED=10010 during the grant, LEDR_N=0.
- Round-robin: all three BTN rise together from reset → grants 001, 010, 100 in that order. Each grant is 8 cycles, with one idle cycle between grants. LED[3]=1 until the third grant starts.
- Pointer fairness: after the grant to 1 completes, press BTN0 and BTN1 together → grant=100 is not involved. Order is 001 then 010 (search starts at index 2, finds 0 first).
- Re-request: press BTN2, then press BTN2 again 3 cycles into its grant → grant=100 for 8 cycles, one IDLE cycle, then grant=100 for another 8 cycles. No grant lasts longer than 8 cycles.
- Hold/glitch: keep BTN0 high 50 cycles → exactly one grant. A 2-cycle low glitch mid-hold produces no second request.
